// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter and other slow-signal
// measurement blocks on the 50 MHz domain.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } pm_state_t;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEFAULT_TIMEOUT_MAX = CLK_HZ - 1;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Synchronizer plus registered edge detector for an asynchronous level;
// reusable for buttons, switches and other slow external inputs.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK_50MHZ,
  input  logic RESET,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2) begin : g_stage_check
    $error("sync_edge_detect: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sig_d_p1;

  always_ff @(posedge CLK_50MHZ or posedge RESET) begin
    if (RESET) begin
      sync_p0  <= '0;
      sig_d_p1 <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      sync_p0  <= {sync_p0[SYNC_STAGES-2:0], async_in};
      // Stage boundary: synchronized level -> delayed copy and edge strobes
      sig_d_p1 <= sync_p0[SYNC_STAGES-1];
      rise     <= sync_p0[SYNC_STAGES-1] & ~sig_d_p1;
      fall     <= ~sync_p0[SYNC_STAGES-1] & sig_d_p1;
    end
  end

  // The delayed copy changes on the same edge the strobes assert, so the
  // level output stays aligned with rise/fall.
  assign level = sig_d_p1;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in
// CLK_50MHZ cycles, with a result strobe and a no-toggle timeout.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_WIDTH   = 26,
  parameter int TIMEOUT_MAX = DEFAULT_TIMEOUT_MAX,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK_50MHZ,
  input  logic                 RESET,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 period_valid,
  output logic                 timeout,
  output logic                 measuring
);

  // counter+1 must fit, so the saturation point leaves one code of headroom
  if (longint'(TIMEOUT_MAX) >= (longint'(1) << CNT_WIDTH) - 1) begin : g_tmo_check
    $error("period_meter: TIMEOUT_MAX must be below 2**CNT_WIDTH-1");
  end

  localparam logic [CNT_WIDTH-1:0] TMAX_C = CNT_WIDTH'(TIMEOUT_MAX);

  logic                 rise_p1;
  logic                 fall_p1;
  logic                 sig_level_unused;
  pm_state_t            state_p2;
  logic [CNT_WIDTH-1:0] cnt_p2;
  logic [CNT_WIDTH-1:0] high_latch_p2;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK_50MHZ (CLK_50MHZ),
    .RESET     (RESET),
    .async_in  (sig_in),
    .level     (sig_level_unused),
    .rise      (rise_p1),
    .fall      (fall_p1)
  );

  // Stage boundary: edge strobes -> cycle counter
  always_ff @(posedge CLK_50MHZ or posedge RESET) begin
    if (RESET) begin
      cnt_p2 <= '0;
    end else if (rise_p1) begin
      cnt_p2 <= '0;
    end else if (cnt_p2 != TMAX_C) begin
      cnt_p2 <= cnt_p2 + 1'b1;
    end
  end

  always_ff @(posedge CLK_50MHZ or posedge RESET) begin
    if (RESET) begin
      high_latch_p2 <= '0;
    end else if (state_p2 == MEASURE && fall_p1) begin
      high_latch_p2 <= cnt_p2 + 1'b1;
    end
  end

  // Stage boundary: counter/edges -> state and published results.
  // A rise on the same cycle the counter saturates is still a valid period.
  always_ff @(posedge CLK_50MHZ or posedge RESET) begin
    if (RESET) begin
      state_p2     <= IDLE;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      measuring    <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state_p2)
        IDLE: begin
          if (rise_p1) begin
            state_p2  <= MEASURE;
            measuring <= 1'b1;
          end
        end
        MEASURE: begin
          if (rise_p1) begin
            period       <= cnt_p2 + 1'b1;
            high_time    <= high_latch_p2;
            period_valid <= 1'b1;
          end else if (cnt_p2 == TMAX_C) begin
            state_p2  <= TIMEOUT;
            timeout   <= 1'b1;
            measuring <= 1'b0;
          end
        end
        TIMEOUT: begin
          // Elapsed time since the last edge is unknown, so no result here
          if (rise_p1) begin
            state_p2  <= MEASURE;
            timeout   <= 1'b0;
            measuring <= 1'b1;
          end
        end
        default: begin
          state_p2  <= IDLE;
          timeout   <= 1'b0;
          measuring <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Randomized waveform bench for period_meter; expected strobes come from a
// rise-gap model of the generated waveform.
module tb_period_meter;

  localparam int CW   = 26;
  localparam int TMAX = 1000;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  logic          CLK_50MHZ = 1'b0;
  logic          RESET;
  logic          sig_in;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          period_valid;
  logic          timeout;
  logic          measuring;

  period_meter #(
    .CNT_WIDTH   (CW),
    .TIMEOUT_MAX (TMAX),
    .SYNC_STAGES (SYNC)
  ) dut (
    .CLK_50MHZ    (CLK_50MHZ),
    .RESET        (RESET),
    .sig_in       (sig_in),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .timeout      (timeout),
    .measuring    (measuring)
  );

  always #10 CLK_50MHZ = ~CLK_50MHZ;

  int cyc = 0;
  always @(posedge CLK_50MHZ) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int p;
    int h;
    int due;
  } exp_t;

  exp_t exp_q[$];
  bit   armed;
  int   last_rise_cyc;
  int   last_h;
  int   last_exp_p;
  bit   mon_en = 1'b0;

  // A rise produces a result only if the previous rise is known and the gap
  // did not exceed TMAX+1 cycles (longer gaps mean a timeout happened).
  task automatic note_rise(input int h);
    int   gap;
    exp_t e;
    gap = cyc - last_rise_cyc;
    if (armed && gap <= TMAX + 1) begin
      e.p = gap;
      e.h = last_h;
      e.due = cyc + LAT;
      exp_q.push_back(e);
      last_exp_p = gap;
    end
    armed = 1'b1;
    last_rise_cyc = cyc;
    last_h = h;
  endtask

  // Called on a falling clock edge; one full input period of p cycles.
  task automatic pulse(input int p, input int h);
    note_rise(h);
    sig_in = 1'b1;
    repeat (h) @(negedge CLK_50MHZ);
    sig_in = 1'b0;
    repeat (p - h) @(negedge CLK_50MHZ);
  endtask

  task automatic stuck_test(input bit hold_high, input int h);
    int c;
    c = cyc;
    note_rise(h);
    sig_in = 1'b1;
    if (!hold_high) begin
      repeat (h) @(negedge CLK_50MHZ);
      sig_in = 1'b0;
    end
    while (cyc < c + LAT + TMAX) @(negedge CLK_50MHZ);
    chk("timeout_early", timeout, 0);
    chk("measuring_before_tmo", measuring, 1);
    @(negedge CLK_50MHZ);
    chk("timeout_asserted", timeout, 1);
    chk("measuring_in_tmo", measuring, 0);
    chk("period_hold", period, last_exp_p);
    sig_in = 1'b0;
    repeat (5) @(negedge CLK_50MHZ);
  endtask

  exp_t m;
  always @(negedge CLK_50MHZ) begin
    if (mon_en && !RESET) begin
      if (period_valid) begin
        if (exp_q.size() == 0) begin
          chk("strobe_unexpected", period_valid, 0);
        end else begin
          m = exp_q.pop_front();
          chk("period", period, m.p);
          chk("high_time", high_time, m.h);
          chk("strobe_latency", cyc, m.due);
          chk("timeout_at_strobe", timeout, 0);
          chk("measuring_at_strobe", measuring, 1);
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
        chk("strobe_missing", period_valid, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int h;
    RESET = 1'b1;
    sig_in = 1'b0;
    armed = 1'b0;
    last_rise_cyc = 0;
    last_h = 0;
    last_exp_p = 0;

    // Reset held while the input toggles
    repeat (8) begin
      @(negedge CLK_50MHZ);
      sig_in = ~sig_in;
    end
    @(negedge CLK_50MHZ);
    chk("rst_period", period, 0);
    chk("rst_high_time", high_time, 0);
    chk("rst_valid", period_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_measuring", measuring, 0);
    sig_in = 1'b0;
    #1 RESET = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge CLK_50MHZ);

    // Steady wave, then duty change
    repeat (6) pulse(100, 40);
    repeat (2) pulse(250, 10);
    pulse(100, 40);

    // Random periods
    for (int i = 0; i < 30; i++) begin
      p = $urandom_range(300, 3);
      h = $urandom_range(p - 1, 1);
      pulse(p, h);
    end

    // Timeout with input held low, then recovery
    repeat (2) pulse(100, 40);
    stuck_test(1'b0, 40);
    pulse(100, 40);
    chk("recover_timeout_clear", timeout, 0);
    chk("recover_measuring", measuring, 1);
    pulse(100, 40);

    // Stuck high
    stuck_test(1'b1, 0);
    pulse(100, 40);

    // Rise exactly at saturation is a result; one cycle later is a timeout
    pulse(1001, 30);
    pulse(1002, 30);
    pulse(100, 40);
    pulse(100, 40);

    // Reset between edges while measuring
    note_rise(40);
    sig_in = 1'b1;
    repeat (20) @(negedge CLK_50MHZ);
    sig_in = 1'b0;
    repeat (10) @(negedge CLK_50MHZ);
    chk("pre_reset_measuring", measuring, 1);
    #3 RESET = 1'b1;
    #1;
    chk("async_rst_period", period, 0);
    chk("async_rst_high_time", high_time, 0);
    chk("async_rst_measuring", measuring, 0);
    chk("async_rst_timeout", timeout, 0);
    chk("async_rst_valid", period_valid, 0);
    repeat (3) @(posedge CLK_50MHZ);
    @(negedge CLK_50MHZ);
    #1 RESET = 1'b0;
    armed = 1'b0;
    @(negedge CLK_50MHZ);
    chk("post_rst_idle", measuring, 0);
    repeat (3) pulse(100, 40);

    repeat (20) @(negedge CLK_50MHZ);
    chk("pending_strobes", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
